spi_mem_ctrl: RTL
=================

Name: spi_mem_ctrl

Overview:
SPI master that services byte-wide memory requests from the control unit. It accepts a request level (start) with a 16-bit address and returns a byte plus a done level. It issues standard serial SRAM/flash READ (0x03) and WRITE (0x02) frames on an external SPI bus. It sits between the CU/datapath and the off-chip program/data memory, and is the responder side of the CU's spi_executing/spi_done handshake.

Parameters:
ADDR_BITS, 24, address field width sent on the bus; the 16-bit addr is zero-extended, MSB first.
READ_CMD, 8'h03, opcode for read frames.
WRITE_CMD, 8'h02, opcode for write frames.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous reset, active-high.
start  input  1  request level; CU spi_executing.
we  input  1  1 = write frame, 0 = read frame; sampled with start.
addr  input  16  byte address; sampled with start.
wdata  input  8  write byte; sampled with start.
done  output  1  completion level; CU spi_done.
data_out  output  8  last byte read; CU irin.
busy  output  1  high from the accepting edge until the IDLE return.
sclk  output  1  SPI clock, mode 0, idle low.
cs_n  output  1  SPI chip select, active-low.
mosi  output  1  SPI master out.
miso  input  1  SPI master in.

Behaviour:
- Reset (rst high at posedge): state=IDLE, done=0, busy=0, cs_n=1, sclk=0, mosi=0, data_out=8'h00, shift and bit counters=0. Reset overrides any state, including mid-frame: cs_n rises on that edge and the frame is abandoned. No done pulse is produced for an abandoned frame.
- States: IDLE, CMD, ADDR, DATA, HOLD, DONE.
- IDLE:
  - On a posedge with start=1, latch we/addr/wdata.
  - Load the shift register with {opcode, zero-extended addr, wdata or 8'h00}, N = 16+ADDR_BITS bits.
  - cs_n<=0, sclk<=0, mosi<=opcode[7], busy<=1, go to CMD.
- Bit timing: each bit takes 2 clk cycles.
  - Low half: sclk=0, mosi holds the current bit.
  - High half: sclk=1.
  - At the edge ending the high half: sample miso into the receive shift register (MSB first), drop sclk to 0, and present the next mosi bit.
- CMD (8 bits) -> ADDR (ADDR_BITS bits) -> DATA (8 bits).
  - In DATA, mosi carries wdata MSB first on writes and 0 on reads.
  - miso samples are kept only during DATA.
- HOLD: entered after the last DATA bit's high half. One cycle with sclk=0, cs_n=0, mosi=0.
- DONE: cs_n<=1 and done<=1 on the same edge.
  - On a read, data_out<=received byte on that edge.
  - On a write, data_out is unchanged.
  - done stays high while start=1 (four-phase handshake).
  - At the first posedge with start=0: done<=0, busy<=0, go to IDLE.
  - A new frame cannot start before start has been observed low.
- Latency: done rises 2*N+1 clocks after the accepting edge. With defaults N=40, that is 81 clocks.
- cs_n is low for exactly 2*N+1 cycles per frame. sclk pulses exactly N times per frame.
- start deasserted mid-frame is ignored; the frame completes and done rises. If start is already low when DONE is reached, done is high for exactly one cycle.
- addr/we/wdata changes after the accepting edge have no effect on the frame in progress.
- data_out is stable between read completions.

Test Plan:
- Read: rst 2 cycles, then start=1, we=0, addr=16'h1234, slave model returns 8'hA5 -> mosi stream 0x03,0x00,0x12,0x34,0x00; 40 sclk pulses; done rises 81 clocks after the accepting edge; data_out=8'hA5; done falls the cycle after start drops.
- Write: we=1, addr=16'hFFFF, wdata=8'h3C -> mosi 0x02,0x00,0xFF,0xFF,0x3C; done asserted; data_out keeps its prior value 8'hA5.
- Back-to-back: hold start high for 10 cycles after done, then pulse low one cycle and high again -> no second frame until start is seen low; the second frame begins at the next start=1 edge with cs_n high for at least 1 cycle between frames.
- Reset mid-frame: assert rst at clock 30 of a read -> next edge gives cs_n=1, sclk=0, done=0, data_out=0, busy=0; a following read of addr 16'h0001 completes normally.
- Early start drop: start low 5 cycles into a read -> frame completes; done is high exactly 1 cycle; data_out updated.
- Mode-0 check (assertion bench): mosi is stable whenever sclk=1; cs_n never toggles while sclk=1; miso sampled only at high-half ends.

Source files
------------

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: SPI mode-0 master issuing READ/WRITE byte frames to serial memory
module spi_mem_ctrl #(
  parameter int ADDR_BITS = 24,
  parameter logic [7:0] READ_CMD = 8'h03,
  parameter logic [7:0] WRITE_CMD = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        done,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);
  localparam int N = 16 + ADDR_BITS;
  localparam int CW = $clog2(N);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD, DONE} state_t;
  state_t state;
  logic [N-1:0] sr;
  logic [7:0] rx;
  logic [CW-1:0] cnt;
  logic we_q;
  logic [7:0] op;
  assign op = we ? WRITE_CMD : READ_CMD;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      busy <= 1'b0;
      cs_n <= 1'b1;
      sclk <= 1'b0;
      mosi <= 1'b0;
      data_out <= 8'h00;
      sr <= '0;
      rx <= 8'h00;
      cnt <= '0;
      we_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          we_q <= we;
          sr <= {op, ADDR_BITS'(addr), we ? wdata : 8'h00};
          cnt <= '0;
          cs_n <= 1'b0;
          sclk <= 1'b0;
          mosi <= op[7];
          busy <= 1'b1;
          state <= CMD;
        end
        CMD, ADDR, DATA: if (!sclk) sclk <= 1'b1;
        else begin
          sclk <= 1'b0;
          sr <= sr << 1;
          mosi <= (cnt == CW'(N - 1)) ? 1'b0 : sr[N-2];
          cnt <= cnt + 1'b1;
          if (state == DATA) rx <= {rx[6:0], miso};
          state <= (cnt == CW'(7)) ? ADDR :
                   (cnt == CW'(7 + ADDR_BITS)) ? DATA :
                   (cnt == CW'(N - 1)) ? HOLD : state;
        end
        HOLD: begin
          cs_n <= 1'b1;
          done <= 1'b1;
          if (!we_q) data_out <= rx;
          state <= DONE;
        end
        DONE: if (!start) begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
